// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the CLA operand-entry and P/G logic.
package cla_pkg;
    localparam int CLA_W = 32;
    localparam int PROP_XOR = 0;
    localparam int PROP_OR = 1;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    // "generate" is a reserved word, so the generate field is named gen
    typedef struct packed {
        logic [CLA_W-1:0] propagate;
        logic [CLA_W-1:0] gen;
        logic [CLA_W-1:0] half_sum;
        logic             cin;
    } pg_beat_t;
endpackage

// File: rtl/cla_pg_gen.sv
// cla_pg_gen: per-bit propagate/generate/half-sum, shared by the ripple, prefix and CLA adders.
module cla_pg_gen #(
    parameter int P_WIDTH = 32
) (
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    input  logic               mode,
    output logic [P_WIDTH-1:0] propagate,
    output logic [P_WIDTH-1:0] gen,
    output logic [P_WIDTH-1:0] half_sum
);
    assign half_sum  = a ^ b;
    assign gen       = a & b;
    assign propagate = mode ? (a | b) : half_sum;
endmodule

// File: rtl/cla_pg_input_stage.sv
// cla_pg_input_stage: registered P/G entry stage with a 2-entry skid buffer on a valid/ready link.
module cla_pg_input_stage
    import cla_pkg::*;
#(
    parameter int P_WIDTH     = 32,
    parameter int P_PROP_MODE = 0,
    parameter int P_CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [P_WIDTH-1:0] a_i,
    input  logic [P_WIDTH-1:0] b_i,
    input  logic               cin_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [P_WIDTH-1:0] propagate_o,
    output logic [P_WIDTH-1:0] generate_o,
    output logic [P_WIDTH-1:0] half_sum_o,
    output logic               cin_o,
    output logic [P_CNT_W-1:0] xfer_cnt_o
);
    localparam int PW = 3 * P_WIDTH + 1;
    logic [P_WIDTH-1:0] p, g, hs;
    logic [PW-1:0] beat, main_q, skid_q;
    state_t state_q, state_d;
    logic in_fire, out_fire, load_main, load_skid, skid_to_main;

    cla_pg_gen #(.P_WIDTH(P_WIDTH)) u_pg (
        .a(a_i), .b(b_i), .mode(P_PROP_MODE == PROP_OR),
        .propagate(p), .gen(g), .half_sum(hs)
    );

    assign beat     = {p, g, hs, cin_i};
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;
    assign valid_o  = state_q != EMPTY;
    assign {propagate_o, generate_o, half_sum_o, cin_o} = main_q;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                load_main = in_fire;
                state_d   = in_fire ? BUSY : EMPTY;
            end
            BUSY: begin
                load_main = in_fire && out_fire;
                load_skid = in_fire && !out_fire;
                state_d   = load_skid ? FULL : (out_fire && !in_fire) ? EMPTY : BUSY;
            end
            FULL: begin
                skid_to_main = out_fire;
                state_d      = out_fire ? BUSY : FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // ready_o is registered from the next state so the upstream ready path stays flop-to-flop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            ready_o    <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            xfer_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            ready_o    <= state_d != FULL;
            main_q     <= load_main ? beat : skid_to_main ? skid_q : main_q;
            skid_q     <= load_skid ? beat : skid_q;
            xfer_cnt_o <= xfer_cnt_o + P_CNT_W'(out_fire);
        end
    end
endmodule

// File: tb/tb_cla_pg_input_stage.sv
// tb_cla_pg_input_stage: scoreboard bench; a second instance covers OR mode and a 4-bit counter.
module tb_cla_pg_input_stage;
    typedef struct {
        logic [31:0] a, p_x, p_o, g, hs;
        logic        cin;
    } exp_t;

    logic        clk = 0, rst_i = 1, valid_i = 0, ready_i = 0, cin_i = 0;
    logic [31:0] a_i = 0, b_i = 0;
    logic        ready_o, valid_o, cin_o, ready_m, valid_m, cin_m;
    logic [31:0] p, g, hs, p_m, g_m, hs_m;
    logic [15:0] cnt, exp_cnt = 0;
    logic [3:0]  cnt_m;
    int n_chk = 0, n_fail = 0, pops = 0, stalls = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    cla_pg_input_stage #(.P_WIDTH(32), .P_PROP_MODE(0), .P_CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .valid_o(valid_o), .ready_i(ready_i),
        .propagate_o(p), .generate_o(g), .half_sum_o(hs), .cin_o(cin_o), .xfer_cnt_o(cnt)
    );

    cla_pg_input_stage #(.P_WIDTH(32), .P_PROP_MODE(1), .P_CNT_W(4)) dut_m (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_m),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .valid_o(valid_m), .ready_i(ready_i),
        .propagate_o(p_m), .generate_o(g_m), .half_sum_o(hs_m), .cin_o(cin_m), .xfer_cnt_o(cnt_m)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: compares the presented beat against the queue head every cycle it is valid
    always @(negedge clk) begin
        if (!rst_i) begin
            chk("xfer_cnt", 32'(cnt), 32'(exp_cnt));
            chk("xfer_cnt4", 32'(cnt_m), 32'(exp_cnt[3:0]));
            chk("valid_or", 32'(valid_m), 32'(valid_o));
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = q[0];
                    chk("propagate", p, e.p_x);
                    chk("generate", g, e.g);
                    chk("half_sum", hs, e.hs);
                    chk("cin", 32'(cin_o), 32'(e.cin));
                    chk("propagate_or", p_m, e.p_o);
                    chk("generate_or", g_m, e.g);
                    chk("half_sum_or", hs_m, e.hs);
                    if (ready_i) begin
                        void'(q.pop_front());
                        exp_cnt = exp_cnt + 16'd1;
                        pops++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, b, input logic c,
                        input logic [31:0] p_x, p_o, gg, h);
        int n = 0;
        exp_t e;
        a_i = a; b_i = b; cin_i = c; valid_i = 1;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n > 0) stalls++;
        if (!ready_o) begin
            chk("send_timeout", 32'(ready_o), 32'd1);
        end else begin
            e.a = a; e.p_x = p_x; e.p_o = p_o; e.g = gg; e.hs = h; e.cin = c;
            q.push_back(e);
        end
        @(posedge clk);
        #1 valid_i = 0;
    endtask

    task automatic send_rand();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        send(a, b, 1'($urandom_range(1)), a ^ b, a | b, a & b, a ^ b);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        rst_i = 0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(ready_o), 32'd1);
        ready_i = 1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
             32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        chk("t1_cnt", 32'(cnt), 32'd1);

        send(32'h0000_00F0, 32'h0000_003C, 1'b1,
             32'h0000_00CC, 32'h0000_00FC, 32'h0000_0030, 32'h0000_00CC);
        drain();

        ready_i = 0;
        send(32'd1, 32'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd1);
        send(32'd2, 32'd0, 1'b0, 32'd2, 32'd2, 32'd0, 32'd2);
        chk("t3_ready_low", 32'(ready_o), 32'd0);
        chk("t3_valid", 32'(valid_o), 32'd1);
        fork
            send(32'd3, 32'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd3);
        join_none
        repeat (4) @(posedge clk);
        #1 ready_i = 1;
        wait fork;
        drain();
        chk("t3_cnt", 32'(cnt), 32'd5);

        stalls = 0;
        p0 = pops;
        for (int i = 0; i < 100; i++) send_rand();
        repeat (2) @(posedge clk);
        #1;
        chk("t4_pops", 32'(pops - p0), 32'd100);
        chk("t4_stalls", 32'(stalls), 32'd0);
        chk("t4_cnt", 32'(cnt), 32'd105);

        ready_i = 0;
        send(32'hA, 32'h5, 1'b1, 32'hF, 32'hF, 32'h0, 32'hF);
        send(32'hB, 32'h6, 1'b0, 32'hD, 32'hF, 32'h2, 32'hD);
        chk("t6_full_ready", 32'(ready_o), 32'd0);
        rst_i = 1;
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        chk("t6_valid", 32'(valid_o), 32'd0);
        chk("t6_ready", 32'(ready_o), 32'd0);
        chk("t6_p", p, 32'd0);
        chk("t6_g", g, 32'd0);
        chk("t6_hs", hs, 32'd0);
        chk("t6_cin", 32'(cin_o), 32'd0);
        chk("t6_cnt", 32'(cnt), 32'd0);
        rst_i = 0;
        @(posedge clk);
        #1;
        chk("t6_ready_up", 32'(ready_o), 32'd1);
        ready_i = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_ghost", 32'(valid_o), 32'd0);

        for (int i = 0; i < 17; i++) send_rand();
        drain();
        chk("t5_cnt4", 32'(cnt_m), 32'd1);
        chk("t5_cnt16", 32'(cnt), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cla_pg_input_stage.md
Name: cla_pg_input_stage

Overview:
Registered operand-entry stage that sits directly upstream of the 32-bit CLA carry logic. It accepts operands A, B and carry-in over a valid/ready handshake and computes per-bit propagate, generate and half-sum (A^B). It presents these, registered, to the carry-logic/sum stage. A 2-entry skid buffer breaks the ready path, so the adder datapath can be pipelined and timed in isolation for architecture comparison.

Parameters:
P_WIDTH, 32, operand width; must equal the downstream CLA size.
P_PROP_MODE, 0, 0: P = A^B; 1: P = A|B. G = A&B in both modes.
P_CNT_W, 16, width of the output-transfer counter.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  upstream operand beat valid
ready_o  output  1  stage can accept a beat (registered)
a_i  input  P_WIDTH  operand A
b_i  input  P_WIDTH  operand B
cin_i  input  1  carry-in
valid_o  output  1  P/G beat valid to CLA stage
ready_i  input  1  CLA/sum stage accepts beat
propagate_o  output  P_WIDTH  propagate vector
generate_o  output  P_WIDTH  generate vector
half_sum_o  output  P_WIDTH  A^B, used for the sum in both modes
cin_o  output  1  registered carry-in
xfer_cnt_o  output  P_CNT_W  count of output handshakes, wraps

Behaviour:
- An input fire occurs when valid_i && ready_o. An output fire occurs when valid_o && ready_i.
- P/G/half_sum are computed combinationally from a_i/b_i. They are captured into the main register or the skid register on an input fire. Latency is 1 cycle from input fire to valid_o when the stage is empty.
- FSM states: EMPTY (main invalid), BUSY (main valid, skid invalid), FULL (both valid).
- EMPTY: valid_o=0.
  - Input fire: load main, go to BUSY.
- BUSY: valid_o=1.
  - Input and output fire in the same cycle: load main with the new beat, stay in BUSY.
  - Output fire only: go to EMPTY.
  - Input fire only: load skid, go to FULL.
  - Neither: hold.
- FULL: valid_o=1, ready_o=0, valid_i is ignored.
  - Output fire: main <= skid, go to BUSY.
  - Otherwise: hold.
- ready_o is a flop. Next value = (next_state != FULL).
- Output payload (propagate_o, generate_o, half_sum_o, cin_o) must stay stable while valid_o=1 && ready_i=0.
- Beats leave in strict arrival order. No beat is dropped or duplicated.
- xfer_cnt_o increments by 1 on each output fire and wraps modulo 2^P_CNT_W without saturating.
- Reset values:
  - state=EMPTY, valid_o=0, ready_o=0, all payload registers 0, xfer_cnt_o=0.
  - ready_o goes to 1 on the first rising edge with rst_i=0.
- Reset mid-operation (any state, including FULL): all buffered beats are discarded. Outputs return to reset values on the next edge. Reset has priority over every fire.
- P_PROP_MODE=1 changes only propagate_o. half_sum_o is always A^B.

Decomposition:
- Package cla_pkg holds:
  - the state enum typedef (EMPTY/BUSY/FULL);
  - a packed struct pg_beat_t {propagate, generate, half_sum, cin} parameterised by a width localparam defaulting to 32;
  - the constants PROP_XOR=0 and PROP_OR=1.
- One sub-module: cla_pg_gen, a combinational block that maps a, b and mode to P, G and half_sum. It is reusable by the ripple and prefix adder variants.
- The skid buffer and FSM stay in the top.

Test Plan:
1. XOR mode, a=0xFFFF_FFFF, b=0x0000_0001, cin=0, ready_i=1 → next cycle valid_o=1, propagate_o=0xFFFF_FFFE, generate_o=0x0000_0001, half_sum_o=0xFFFF_FFFE, cin_o=0, xfer_cnt_o=1.
2. OR mode, a=0x0000_00F0, b=0x0000_003C, cin=1 → propagate_o=0x0000_00FC, generate_o=0x0000_0030, half_sum_o=0x0000_00CC, cin_o=1.
3. Backpressure: ready_i=0, present beats a=1, 2, 3 back-to-back.
   - ready_o falls after the 2nd fire; beat 3 is held upstream.
   - Then raise ready_i: output order is 1, 2, 3, each stable while stalled. xfer_cnt_o=3.
4. Streaming: valid_i=ready_i=1 for 100 random beats → one output per cycle after 1-cycle latency, no bubbles, ready_o stays 1, xfer_cnt_o=100.
5. P_CNT_W=4: 17 output fires → xfer_cnt_o=1.
6. Reach FULL, assert rst_i for 1 cycle → next edge valid_o=0, ready_o=0, state EMPTY, payload 0. Following edge ready_o=1. Buffered beats never appear.
